// File: rtl/wb_regfile_pkg.sv
// Shared sizes, types and the write-back select helper for the WB stage register file.
// No logic of its own; latency n/a.
// No flow control; pure definitions.
package wb_regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t REG_X0 = 5'd0;

  // Loads return memory data, everything else commits the ALU result.
  function automatic xlen_t wb_select(input logic mem_to_reg, input xlen_t rdata, input xlen_t alu);
    return mem_to_reg ? rdata : alu;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM_WB commit, ID read-port and issue/hazard signals between pipeline and register file.
// Wires only; no latency.
// No backpressure; stalls are decided by ID from load_hazard_o.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic      RegWrite_i;
  logic      MemtoReg_i;
  xlen_t     read_data_i;
  xlen_t     ALU_result_i;
  reg_addr_t rd_i;
  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  xlen_t     rs1_data_o;
  xlen_t     rs2_data_o;
  logic      issue_valid_i;
  logic      issue_load_i;
  reg_addr_t issue_rd_i;
  logic      flush_i;
  logic      load_hazard_o;

  // Register file side.
  modport slave (
    input  RegWrite_i, MemtoReg_i, read_data_i, ALU_result_i, rd_i,
    input  rs1_addr_i, rs2_addr_i,
    input  issue_valid_i, issue_load_i, issue_rd_i, flush_i,
    output rs1_data_o, rs2_data_o, load_hazard_o
  );

  // Pipeline side.
  modport master (
    output RegWrite_i, MemtoReg_i, read_data_i, ALU_result_i, rd_i,
    output rs1_addr_i, rs2_addr_i,
    output issue_valid_i, issue_load_i, issue_rd_i, flush_i,
    input  rs1_data_o, rs2_data_o, load_hazard_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register "load in flight" bits and load-use hazard lookup for two read addresses.
// Pending bits update at posedge; hazard output is combinational from state and WB inputs.
// No backpressure; hazard is advisory to the ID stall logic.
module wb_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      set_vld_i,   // load issued this cycle
  input  reg_addr_t set_rd_i,
  input  logic      clr_vld_i,   // load writing back this cycle
  input  reg_addr_t clr_rd_i,
  input  logic      flush_i,
  input  reg_addr_t rs1_addr_i,
  input  reg_addr_t rs2_addr_i,
  output logic      hazard_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            rs1_pend;
  logic            rs2_pend;

  // Next pending state: flush first, then writeback clear, then issue set so a newer load wins.
  always_comb begin
    pending_d = flush_i ? '0 : pending_q;
    if (clr_vld_i && clr_rd_i != REG_X0) begin
      pending_d[clr_rd_i] = 1'b0;
    end
    if (set_vld_i && set_rd_i != REG_X0) begin
      pending_d[set_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending register; reset overrides flush and issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A load committing this cycle is served by the bypass, so it is not a hazard.
  assign rs1_pend = (rs1_addr_i != REG_X0) && pending_q[rs1_addr_i] &&
                    !(clr_vld_i && clr_rd_i == rs1_addr_i);
  assign rs2_pend = (rs2_addr_i != REG_X0) && pending_q[rs2_addr_i] &&
                    !(clr_vld_i && clr_rd_i == rs2_addr_i);
  assign hazard_o = rs1_pend || rs2_pend;

endmodule

// File: rtl/wb_regfile.sv
// WB stage: selects load/ALU value, commits to the 32x32 register file, serves two bypassed read ports.
// Commit at posedge; reads and hazard are combinational (0-cycle WB bypass).
// No backpressure; load_hazard_o tells ID to stall, read ports ignore pending state.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  wb_regfile_if.slave  bus
);

  xlen_t regs_q [NREG];
  xlen_t regs_d [NREG];
  xlen_t wb_data;
  logic  wb_commit;
  xlen_t rs1_data;
  xlen_t rs2_data;

  assign wb_data   = wb_select(bus.MemtoReg_i, bus.read_data_i, bus.ALU_result_i);
  assign wb_commit = bus.RegWrite_i && (bus.rd_i != REG_X0);

  // Next register-file contents: single write port, x0 never written.
  always_comb begin
    regs_d = regs_q;
    if (wb_commit) begin
      regs_d[bus.rd_i] = wb_data;
    end
  end

  // Register file storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: x0 reads zero, a same-cycle commit to the address is bypassed.
  always_comb begin
    rs1_data = regs_q[bus.rs1_addr_i];
    if (bus.RegWrite_i && bus.rd_i == bus.rs1_addr_i) begin
      rs1_data = wb_data;
    end
    if (bus.rs1_addr_i == REG_X0) begin
      rs1_data = '0;
    end
    rs2_data = regs_q[bus.rs2_addr_i];
    if (bus.RegWrite_i && bus.rd_i == bus.rs2_addr_i) begin
      rs2_data = wb_data;
    end
    if (bus.rs2_addr_i == REG_X0) begin
      rs2_data = '0;
    end
  end

  assign bus.rs1_data_o = rs1_data;
  assign bus.rs2_data_o = rs2_data;

  wb_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_vld_i  (bus.issue_valid_i && bus.issue_load_i),
    .set_rd_i   (bus.issue_rd_i),
    .clr_vld_i  (bus.RegWrite_i && bus.MemtoReg_i),
    .clr_rd_i   (bus.rd_i),
    .flush_i    (bus.flush_i),
    .rs1_addr_i (bus.rs1_addr_i),
    .rs2_addr_i (bus.rs2_addr_i),
    .hazard_o   (bus.load_hazard_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: table of per-cycle vectors plus hand sequences for reset and write/readback.
// Inputs change 1 time unit after posedge; outputs are compared at negedge before the commit edge.
// Expected outputs are queued when a vector is driven and popped when outputs are sampled.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        chk;
    logic        rst;
    logic        we;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic        il;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic c, logic r, logic we, logic m2r,
                              logic [31:0] rdata, logic [31:0] alu, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic iv, logic il,
                              logic [4:0] ird, logic fl, logic [31:0] e1, logic [31:0] e2,
                              logic eh);
    vec_t v;
    v.name = n; v.chk = c; v.rst = r; v.we = we; v.m2r = m2r;
    v.rdata = rdata; v.alu = alu; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.iv = iv; v.il = il; v.ird = ird; v.fl = fl;
    v.e1 = e1; v.e2 = e2; v.eh = eh;
    return v;
  endfunction

  // Idle read of two addresses with expected results.
  function automatic vec_t rd2(string n, logic [4:0] a1, logic [4:0] a2,
                               logic [31:0] e1, logic [31:0] e2, logic eh);
    return mk(n, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, a1, a2,
              1'b0, 1'b0, 5'd0, 1'b0, e1, e2, eh);
  endfunction

  function automatic logic [31:0] wv(int a);
    return 32'h1000_0000 | (32'(a) << 16) | (32'(a) ^ 32'h5A);
  endfunction

  task automatic cmp(string nm, string what, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, what, act, expv);
    end
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    rst                = v.rst;
    bus.RegWrite_i     = v.we;
    bus.MemtoReg_i     = v.m2r;
    bus.read_data_i    = v.rdata;
    bus.ALU_result_i   = v.alu;
    bus.rd_i           = v.rd;
    bus.rs1_addr_i     = v.rs1;
    bus.rs2_addr_i     = v.rs2;
    bus.issue_valid_i  = v.iv;
    bus.issue_load_i   = v.il;
    bus.issue_rd_i     = v.ird;
    bus.flush_i        = v.fl;
    if (v.chk) begin
      e.name = v.name; e.e1 = v.e1; e.e2 = v.e2; e.eh = v.eh;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    cmp(e.name, "rs1_data", bus.rs1_data_o, e.e1);
    cmp(e.name, "rs2_data", bus.rs2_data_o, e.e2);
    cmp(e.name, "hazard", {31'b0, bus.load_hazard_o}, {31'b0, e.eh});
  endtask

  task automatic run(vec_t v);
    drive(v);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;

    // Reset with a write to x5 and a load issue to x9 that must both be ignored.
    run(mk("reset", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd0,
           1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0, 1'b0));
    for (int a = 1; a < 32; a++) begin
      run(rd2("post_reset", 5'(a), 5'(32 - a), 32'h0, 32'h0, 1'b0));
    end

    // name chk rst we m2r rdata alu rd rs1 rs2 iv il ird fl e1 e2 eh
    vecs.push_back(mk("x0_wr",      1,0,1,0, 32'h0,      32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 0,0,5'd0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(rd2("x0_next",   5'd0, 5'd0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("byp_alu",    1,0,1,0, 32'hFFFF,   32'h1234, 5'd7, 5'd6, 5'd7, 0,0,5'd0, 0, 32'h0, 32'h1234, 0));
    vecs.push_back(rd2("byp_hold",  5'd7, 5'd7, 32'h1234, 32'h1234, 0));
    vecs.push_back(mk("byp_mem",    1,0,1,1, 32'hCAFE,   32'h1111, 5'd8, 5'd8, 5'd7, 0,0,5'd0, 0, 32'hCAFE, 32'h1234, 0));
    vecs.push_back(mk("we_off",     1,0,0,1, 32'h9999,   32'h0,    5'd8, 5'd8, 5'd0, 0,0,5'd0, 0, 32'hCAFE, 32'h0, 0));
    vecs.push_back(mk("issue_ld9",  1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd9, 5'd8, 1,1,5'd9, 0, 32'h0, 32'hCAFE, 0));
    vecs.push_back(rd2("haz9_rs1",  5'd9, 5'd0, 32'h0, 32'h0, 1));
    vecs.push_back(rd2("haz9_rs2",  5'd8, 5'd9, 32'hCAFE, 32'h0, 1));
    vecs.push_back(mk("ld9_wb",     1,0,1,1, 32'hA5A5,   32'h0,    5'd9, 5'd9, 5'd9, 0,0,5'd0, 0, 32'hA5A5, 32'hA5A5, 0));
    vecs.push_back(rd2("ld9_done",  5'd9, 5'd7, 32'hA5A5, 32'h1234, 0));
    vecs.push_back(mk("issue_ld10", 1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd0, 5'd0, 1,1,5'd10, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("alu_wr10",   1,0,1,0, 32'h0,      32'h7777, 5'd10, 5'd10, 5'd0, 0,0,5'd0, 0, 32'h7777, 32'h0, 1));
    vecs.push_back(mk("nonld_10",   1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd10, 5'd0, 1,0,5'd10, 0, 32'h7777, 32'h0, 1));
    vecs.push_back(rd2("still_10",  5'd0, 5'd10, 32'h0, 32'h7777, 1));
    vecs.push_back(mk("ld10_wb",    1,0,1,1, 32'h0BAD,   32'h0,    5'd10, 5'd3, 5'd10, 1,1,5'd3, 0, 32'h0, 32'h0BAD, 0));
    vecs.push_back(mk("collide3",   1,0,1,1, 32'h3333,   32'h0,    5'd3, 5'd3, 5'd0, 1,1,5'd3, 0, 32'h3333, 32'h0, 0));
    vecs.push_back(rd2("after_col", 5'd3, 5'd10, 32'h3333, 32'h0BAD, 1));
    vecs.push_back(mk("issue_ld4",  1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd0, 5'd0, 1,1,5'd4, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("issue_ld6",  1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd4, 5'd0, 1,1,5'd6, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk("flush_ld6",  1,0,0,0, 32'h0,      32'h0,    5'd0, 5'd4, 5'd6, 1,1,5'd6, 1, 32'h0, 32'h0, 1));
    vecs.push_back(rd2("fl_4clr",   5'd4, 5'd0, 32'h0, 32'h0, 0));
    vecs.push_back(rd2("fl_6set",   5'd6, 5'd3, 32'h0, 32'h3333, 1));
    vecs.push_back(rd2("fl_3clr",   5'd3, 5'd0, 32'h3333, 32'h0, 0));
    vecs.push_back(mk("x0_ldwb",    1,0,1,1, 32'hFFFF,   32'h0,    5'd0, 5'd0, 5'd6, 1,1,5'd0, 0, 32'h0, 32'h0, 1));
    vecs.push_back(rd2("x0_idle",   5'd0, 5'd0, 32'h0, 32'h0, 0));

    foreach (vecs[i]) begin
      run(vecs[i]);
    end

    // Reset while x6 load is pending and registers hold data.
    run(mk("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1, 5'd11, 5'd0, 5'd0,
           1'b1, 1'b1, 5'd12, 1'b0, 32'h0, 32'h0, 1'b0));
    run(rd2("mrst_a", 5'd6, 5'd11, 32'h0, 32'h0, 1'b0));
    run(rd2("mrst_b", 5'd3, 5'd12, 32'h0, 32'h0, 1'b0));
    run(rd2("mrst_c", 5'd10, 5'd9, 32'h0, 32'h0, 1'b0));

    // Write every register through alternating WB sources, checking bypass on the way.
    for (int a = 1; a < 32; a++) begin
      logic        ld;
      logic [31:0] prev;
      ld   = (a % 2) == 1;
      prev = (a == 1) ? 32'h0 : wv(a - 1);
      run(mk("wr_all", 1'b1, 1'b0, 1'b1, ld, ld ? wv(a) : ~wv(a), ld ? ~wv(a) : wv(a),
             5'(a), 5'(a), 5'(a - 1), 1'b0, 1'b0, 5'd0, 1'b0, wv(a), prev, 1'b0));
    end
    for (int a = 1; a < 32; a++) begin
      run(rd2("rdback", 5'(a), 5'(32 - a), wv(a), wv(32 - a), 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
